ln1p_series_seq: RTL

Parametrised successor to the fixed 5-term pipelined ln(1+x) core. It evaluates ln(1+x) as a Taylor series with N_TERMS terms, using Horner's method on one shared mult unit and one shared add unit, sequenced by an FSM. It trades throughput for area and a configurable term count. It sits beside the pipelined core in the math library and uses the same start/done/error contract, plus a busy output.

---
 rtl/ln_pkg.sv | 32 +++
 rtl/fp_add.sv | 58 +++++
 rtl/fp_mult.sv | 45 ++++
 rtl/ln_op_timer.sv | 21 ++
 rtl/ln1p_series_seq.sv | 96 +++++++++
 5 files changed

// File: rtl/ln_pkg.sv
// Shared constants, series coefficients and sequencer state type for the ln(1+x) cores.
package ln_pkg;
    localparam logic [31:0] ONE         = 32'h3f800000;
    localparam logic [31:0] ONE_HALF    = 32'h3f000000;
    localparam logic [31:0] ONE_THIRD   = 32'h3eaaaaab;
    localparam logic [31:0] ONE_FOURTH  = 32'h3e800000;
    localparam logic [31:0] ONE_FIFTH   = 32'h3e4ccccd;
    localparam logic [31:0] ONE_SIXTH   = 32'h3e2aaaab;
    localparam logic [31:0] ONE_SEVENTH = 32'h3e124925;
    localparam logic [31:0] ONE_EIGHTH  = 32'h3e000000;

    typedef enum logic [2:0] {
        IDLE, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, DONE
    } ln_seq_state_t;

    // c[k] = (-1)^(k+1)/k: even k carries the sign bit, so subtraction is a signed add.
    function automatic logic [31:0] coeff(input logic [3:0] k);
        logic [30:0] mag;
        case (k)
            4'd1:    mag = ONE[30:0];
            4'd2:    mag = ONE_HALF[30:0];
            4'd3:    mag = ONE_THIRD[30:0];
            4'd4:    mag = ONE_FOURTH[30:0];
            4'd5:    mag = ONE_FIFTH[30:0];
            4'd6:    mag = ONE_SIXTH[30:0];
            4'd7:    mag = ONE_SEVENTH[30:0];
            4'd8:    mag = ONE_EIGHTH[30:0];
            default: mag = '0;
        endcase
        return {~k[0], mag};
    endfunction
endpackage

// File: rtl/fp_add.sv
// Single-precision adder, round-to-nearest-even, denormals flushed to zero.
// Free-running fixed-latency pipeline: result appears LAT cycles after the operands.
module fp_add #(
    parameter int unsigned LAT = 14
) (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);
    logic [31:0] big, sml, res;
    logic [23:0] mb, ms;
    logic [7:0]  d;
    logic [26:0] mx, shf, sh, n;
    logic [27:0] sum;
    logic [24:0] r;
    logic        inc;
    int unsigned lz;
    int          e;
    logic [31:0] pipe [LAT];

    always_comb begin
        if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
        else begin big = b; sml = a; end
        mb  = (big[30:23] == '0) ? '0 : {1'b1, big[22:0]};
        ms  = (sml[30:23] == '0) ? '0 : {1'b1, sml[22:0]};
        d   = big[30:23] - sml[30:23];
        mx  = {ms, 3'b000};
        shf = mx >> d;
        // Bits shifted out of the smaller operand fold into the sticky bit.
        sh  = (d >= 8'd27) ? {26'd0, |ms} : {shf[26:1], shf[0] | (|(mx & ~({27{1'b1}} << d)))};
        if (big[31] == sml[31]) sum = {1'b0, mb, 3'b000} + {1'b0, sh};
        else sum = {1'b0, mb, 3'b000} - {1'b0, sh};
        lz = 0;
        for (int unsigned i = 0; i < 27; i++) if (sum[i]) lz = 26 - i;
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = int'(big[30:23]) + 1;
        end else begin
            n = sum[26:0] << lz;
            e = int'(big[30:23]) - int'(lz);
        end
        inc = n[2] & (n[1] | n[0] | n[3]);
        r   = {1'b0, n[26:3]} + 25'(inc);
        if (r[24]) e = e + 1;
        if (sum == '0) res = {a[31] & b[31], 31'd0};
        else if (e <= 0) res = {big[31], 31'd0};
        else if (e >= 255) res = {big[31], 8'hff, 23'd0};
        else res = {big[31], e[7:0], r[24] ? r[23:1] : r[22:0]};
    end

    always_ff @(posedge clk) begin
        pipe[0] <= res;
        for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign s = pipe[LAT-1];
endmodule

// File: rtl/fp_mult.sv
// Single-precision multiplier, round-to-nearest-even, denormals flushed to zero.
// Free-running fixed-latency pipeline: result appears LAT cycles after the operands.
module fp_mult #(
    parameter int unsigned LAT = 11
) (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    logic [47:0] m;
    logic [22:0] frac;
    logic        grd, stk;
    logic [24:0] r;
    int          e;
    logic [31:0] res;
    logic [31:0] pipe [LAT];

    always_comb begin
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            e    = e + 1;
            frac = m[46:24];
            grd  = m[23];
            stk  = |m[22:0];
        end else begin
            frac = m[45:23];
            grd  = m[22];
            stk  = |m[21:0];
        end
        r = {2'b01, frac} + 25'(grd & (stk | frac[0]));
        if (r[24]) e = e + 1;
        if (a[30:23] == '0 || b[30:23] == '0 || e <= 0) res = {a[31] ^ b[31], 31'd0};
        else if (e >= 255) res = {a[31] ^ b[31], 8'hff, 23'd0};
        else res = {a[31] ^ b[31], e[7:0], r[24] ? r[23:1] : r[22:0]};
    end

    always_ff @(posedge clk) begin
        pipe[0] <= res;
        for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign p = pipe[LAT-1];
endmodule

// File: rtl/ln_op_timer.sv
// Issue/wait down-counter: loaded when an operation is issued, flags the final wait cycle.
module ln_op_timer #(
    parameter int unsigned MAX_LAT = 14,
    localparam int unsigned W = $clog2(MAX_LAT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] lat,
    output logic         last
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= lat;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign last = (cnt == W'(1));
endmodule

// File: rtl/ln1p_series_seq.sv
// Sequential ln(1+x) series core: Horner evaluation on one shared multiplier and adder.
import ln_pkg::*;

module ln1p_series_seq #(
    parameter int unsigned N_TERMS    = 5,
    parameter int unsigned MULT_LAT   = 11,
    parameter int unsigned ADD_LAT    = 14,
    parameter logic [31:0] ERR_RESULT = 32'h7fc00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] x,
    input  logic        start,
    output logic        busy,
    output logic [31:0] ln,
    output logic        done,
    output logic        error
);
    localparam int unsigned MAX_LAT = (MULT_LAT > ADD_LAT) ? MULT_LAT : ADD_LAT;
    localparam int unsigned TW      = $clog2(MAX_LAT + 1);

    if (N_TERMS < 2 || N_TERMS > 8) begin : g_bad_terms
        $error("ln1p_series_seq: N_TERMS must be in 2..8");
    end

    ln_seq_state_t state;
    logic [31:0]   x_q, acc, coef, mul_p, add_s;
    logic [3:0]    k;
    logic          tmr_load, tmr_last;
    logic [TW-1:0] tmr_lat;

    assign coef     = coeff(k);
    assign tmr_load = (state == MUL_ISSUE) || (state == ADD_ISSUE);
    assign tmr_lat  = (state == MUL_ISSUE) ? TW'(MULT_LAT) : TW'(ADD_LAT);

    fp_mult #(.LAT(MULT_LAT)) u_mult (.clk(clk), .a(acc), .b(x_q), .p(mul_p));
    fp_add  #(.LAT(ADD_LAT))  u_add  (.clk(clk), .a(acc), .b(coef), .s(add_s));

    ln_op_timer #(.MAX_LAT(MAX_LAT)) u_timer (
        .clk(clk), .rst_n(rst_n), .load(tmr_load), .lat(tmr_lat), .last(tmr_last)
    );

    // Operands come straight from acc/x_q/k, which stay frozen through each WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x_q   <= '0;
            acc   <= '0;
            k     <= '0;
            ln    <= '0;
            done  <= 1'b0;
            error <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x_q  <= x;
                    busy <= 1'b1;
                    if ({1'b0, x[30:0]} >= ONE) begin
                        state <= DONE;
                        done  <= 1'b1;
                        error <= 1'b1;
                        ln    <= ERR_RESULT;
                    end else begin
                        state <= MUL_ISSUE;
                        acc   <= coeff(4'(N_TERMS));
                        k     <= 4'(N_TERMS - 1);
                    end
                end
                MUL_ISSUE: state <= MUL_WAIT;
                MUL_WAIT: if (tmr_last) begin
                    acc <= mul_p;
                    if (k != '0) state <= ADD_ISSUE;
                    else begin
                        state <= DONE;
                        done  <= 1'b1;
                        error <= 1'b0;
                        ln    <= mul_p;
                    end
                end
                ADD_ISSUE: state <= ADD_WAIT;
                ADD_WAIT: if (tmr_last) begin
                    acc   <= add_s;
                    k     <= k - 4'd1;
                    state <= MUL_ISSUE;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
